// File: rtl/rv_pkg.sv
// Shared RV32I definitions: widths, reset PC, opcodes and
// instruction field helpers used by fetch and decode.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_R     = 7'b0110011,
        OP_I     = 7'b0010011,
        OP_LOAD  = 7'b0000011,
        OP_S     = 7'b0100011,
        OP_B     = 7'b1100011,
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111
    } opcode_e;

    function automatic logic [6:0] f_opcode(input logic [ILEN-1:0] i);
        return i[6:0];
    endfunction

    function automatic logic [4:0] f_rd(input logic [ILEN-1:0] i);
        return i[11:7];
    endfunction

    function automatic logic [2:0] f_funct3(input logic [ILEN-1:0] i);
        return i[14:12];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [ILEN-1:0] i);
        return i[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [ILEN-1:0] i);
        return i[24:20];
    endfunction

    function automatic logic [6:0] f_funct7(input logic [ILEN-1:0] i);
        return i[31:25];
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous fetch buffer of {pc, instr} entries.
// Flush dominates push and pop in the same cycle.
module rv_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 wdata,
    input  logic                             pop,
    input  logic                             flush,
    output logic [WIDTH-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; consumers qualify it with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I instruction fetch: PC, credit-limited memory requests,
// in-order response tracking and redirect flush.
module rv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    import rv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = XLEN + ILEN;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    assign in_use   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign target   = redirect_pc & ~XLEN'(3);

    assign imem_req_valid = !rst && !redirect_valid
                          && (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight are leftovers from before reset.
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    assign push     = rsp_take && (discard == '0) && !redirect_valid;

    assign if_valid = !fifo_empty && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign if_pc    = if_valid ? head[EW-1:ILEN] : '0;
    assign if_instr = if_valid ? head[ILEN-1:0] : '0;

    always_comb begin
        outstanding_nxt = outstanding;
        unique case ({req_fire, rsp_take})
            2'b10:   outstanding_nxt = outstanding + CW'(1);
            2'b01:   outstanding_nxt = outstanding - CW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                pc      <= target;
                rsp_pc  <= target;
                discard <= outstanding_nxt;
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (push)     rsp_pc <= rsp_pc + XLEN'(4);
                if (rsp_take && (discard != '0))
                    discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full));
    end

    rv_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({rsp_pc, imem_rsp_data}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
